z80_bus_target: RTL and testbench
=================================

# z80_bus_target

Pin-level Z80 bus responder for the tv80s CPU wrapper. It watches `mreq_n`, `iorq_n`, `rd_n`, `wr_n` and `m1_n`, converts each CPU memory or I/O cycle into a single request/acknowledge transaction on a simple backend port, and holds `wait_n` low until the backend completes. It also answers interrupt-acknowledge cycles with a vector, and aborts hung backend accesses after a programmable timeout. It sits between the CPU and the SoC memory/peripheral fabric.

## Interface
- `TIMEOUT`, default 255: ACCESS-state cycles without `bus_ack` before the access is aborted. Valid range 1..255; the counter is 8 bits.
- `clk`  in  1  clock.
- `reset_n`  in  1  reset. Synchronous, active-low.
- `mreq_n`, `iorq_n`, `rd_n`, `wr_n`, `m1_n`  in  1 each  CPU bus strobes (registered outputs of the CPU wrapper).
- `A`  in  16  CPU address.
- `cpu_dout`  in  8  CPU write data.
- `cpu_din`  out  8  read data to the CPU `data_in`. Registered.
- `wait_n`  out  1  wait request to the CPU. Combinational.
- `bus_req`  out  1  backend request. Registered; level held until ack or abort.
- `bus_we`  out  1  1 = write.
- `bus_io`  out  1  1 = I/O space, 0 = memory.
- `bus_addr`  out  16  latched address.
- `bus_wdata`  out  8  latched write data.
- `bus_ack`  in  1  backend completion. Single-cycle pulse, valid only while `bus_req`=1.
- `bus_rdata`  in  8  read data, valid with `bus_ack`.
- `int_vec`  in  8  interrupt vector.
- `intack`  out  1  one-cycle pulse when a vector is delivered.
- `err`  out  1  one-cycle pulse on timeout abort.

## Operation
- Start condition (`start`), evaluated only in IDLE:
  - `mem_rw` = `!mreq_n & (!rd_n | !wr_n)`.
  - `io_rw` = `!iorq_n & m1_n & (!rd_n | !wr_n)`.
  - `ack_cyc` = `!iorq_n & !m1_n`.
  - Refresh cycles (`mreq_n` low with `rd_n`=`wr_n`=1) never start a cycle.
- FSM states IDLE, ACCESS, DONE.
  - **IDLE**, on `mem_rw` or `io_rw`:
    - latch `bus_addr`=`A`, `bus_we`=`!wr_n`, `bus_io`=`!iorq_n`, `bus_wdata`=`cpu_dout`;
    - set `bus_req`=1, clear the timeout counter, go to ACCESS.
  - **IDLE**, on `ack_cyc`: handled as described under Configuration.
  - **ACCESS**, on `bus_ack`:
    - `cpu_din`=`bus_rdata` for reads; `cpu_din` is unchanged for writes;
    - set `bus_req`=0, go to DONE.
  - **ACCESS**, counter reaches `TIMEOUT` with no ack:
    - `cpu_din`=0xFF, `err`=1 for one cycle, `bus_req`=0, go to DONE.
  - **DONE**: stay until all of `mreq_n`, `iorq_n`, `rd_n`, `wr_n` are 1, then go to IDLE.
- `wait_n` = `!((IDLE & start) | ACCESS)`.
- `bus_ack` is ignored in IDLE and DONE. A late ack after an abort has no effect.
- Reset values: state IDLE, `cpu_din`=0x00, `bus_req`=0, `bus_we`=0, `bus_io`=0, `bus_addr`=0, `bus_wdata`=0, `intack`=0, `err`=0, counter=0. `wait_n` is forced to 1 while `reset_n`=0.
- Reset mid-cycle aborts any outstanding request with no `err` pulse.

## Timing
- The CPU asserts strobes at the T1 edge. `wait_n` falls combinationally in that same cycle (cycle c), so the CPU inserts Tw.
- Edge c→c+1: enter ACCESS with `bus_req`=1.
- Ack in cycle c+k (k≥1): DONE at c+k+1 with `wait_n`=1 and `cpu_din` valid. The CPU samples `cpu_din` on the next edge.
- Minimum added wait states: 2 for backend cycles, 1 for the internal interrupt-acknowledge path.
- Timeout: abort takes effect on the edge after `TIMEOUT` ACCESS cycles.
- Back-to-back CPU cycles: DONE must observe a strobe-idle cycle before IDLE accepts the next start. The CPU always provides at least one such cycle between bus cycles.

## Configuration
- Macro: `Z80_TGT_INTACK_EN`.
- Defined:
  - `ack_cyc` in IDLE sets `cpu_din`=`int_vec` and pulses `intack` for one cycle.
  - The FSM goes directly to DONE; `wait_n` is low only in the start cycle.
  - No backend request is issued.
- Undefined:
  - `ack_cyc` goes directly to DONE with `cpu_din`=0xFF.
  - `intack` is tied to 0 and no backend request is issued.

## Test plan
- **Memory read:** CPU reads 0x1234, backend acks after 3 cycles with 0x5A.
  - Expected: `bus_req`=1, `bus_we`=0, `bus_io`=0, `bus_addr`=0x1234; `wait_n` low for 4 cycles; CPU receives 0x5A.
- **I/O write:** OUT (0x7F),0xC3, backend acks immediately.
  - Expected: `bus_io`=1, `bus_we`=1, `bus_addr`[7:0]=0x7F, `bus_wdata`=0xC3; `wait_n` low for 2 cycles.
- **Timeout:** `TIMEOUT`=4, backend never acks.
  - Expected: `err` pulses once, `cpu_din`=0xFF, `bus_req` drops after 4 ACCESS cycles.
  - A late `bus_ack` is then ignored, and the next CPU cycle completes normally.
- **Interrupt acknowledge:** IM2 acknowledge with `int_vec`=0x40.
  - With `Z80_TGT_INTACK_EN`: `intack` pulse, CPU reads 0x40, no `bus_req`.
  - Without it: CPU reads 0xFF, no `intack`, no `bus_req`.
- **Refresh only:** `mreq_n` low with `rd_n`=`wr_n`=1.
  - Expected: no `bus_req`, `wait_n` stays 1.
- **Reset mid-access:** `reset_n` low while in ACCESS.
  - Expected: next edge gives IDLE, `bus_req`=0, `wait_n`=1, no `err`.

Source files
------------

// File: rtl/z80_bus_target.sv
// z80_bus_target: converts tv80s pin-level memory/I/O cycles into single req/ack backend transactions.
// Build option Z80_TGT_INTACK_EN: interrupt-acknowledge cycles return int_vec with an intack pulse.
module z80_bus_target #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        m1_n,
    input  logic [15:0] A,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        wait_n,
    output logic        bus_req,
    output logic        bus_we,
    output logic        bus_io,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    input  logic        bus_ack,
    input  logic [7:0]  bus_rdata,
    input  logic [7:0]  int_vec,
    output logic        intack,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 32'd1);

    state_t      state_r;
    logic [7:0]  cnt_r;
    logic [7:0]  cpu_din_r;
    logic        bus_req_r;
    logic        bus_we_r;
    logic        bus_io_r;
    logic [15:0] bus_addr_r;
    logic [7:0]  bus_wdata_r;
    logic        intack_r;
    logic        err_r;

    logic mem_rw_s;
    logic io_rw_s;
    logic ack_cyc_s;
    logic start_s;
    logic strobes_idle_s;
    logic wait_s;

    assign mem_rw_s       = ~mreq_n & (~rd_n | ~wr_n);
    assign io_rw_s        = ~iorq_n & m1_n & (~rd_n | ~wr_n);
    assign ack_cyc_s      = ~iorq_n & ~m1_n;
    assign start_s        = mem_rw_s | io_rw_s | ack_cyc_s;
    assign strobes_idle_s = mreq_n & iorq_n & rd_n & wr_n;

    // Wait request: low in the start cycle and throughout ACCESS, released during reset.
    always_comb begin
        wait_s = 1'b0;
        if (!reset_n) begin
            wait_s = 1'b0;
        end else if (state_r == ST_ACCESS) begin
            wait_s = 1'b1;
        end else if ((state_r == ST_IDLE) && start_s) begin
            wait_s = 1'b1;
        end else begin
            wait_s = 1'b0;
        end
    end

    assign wait_n    = ~wait_s;
    assign cpu_din   = cpu_din_r;
    assign bus_req   = bus_req_r;
    assign bus_we    = bus_we_r;
    assign bus_io    = bus_io_r;
    assign bus_addr  = bus_addr_r;
    assign bus_wdata = bus_wdata_r;
    assign intack    = intack_r;
    assign err       = err_r;

`ifndef Z80_TGT_INTACK_EN
    logic int_vec_unused_s;
    assign int_vec_unused_s = ^int_vec;
`endif

    // Cycle FSM: latches the CPU cycle, runs the backend handshake and the abort timer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 8'd0;
            cpu_din_r   <= 8'h00;
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_io_r    <= 1'b0;
            bus_addr_r  <= 16'h0000;
            bus_wdata_r <= 8'h00;
            intack_r    <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            intack_r <= 1'b0;
            err_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (mem_rw_s | io_rw_s) begin
                        bus_addr_r  <= A;
                        bus_we_r    <= ~wr_n;
                        bus_io_r    <= ~iorq_n;
                        bus_wdata_r <= cpu_dout;
                        bus_req_r   <= 1'b1;
                        cnt_r       <= 8'd0;
                        state_r     <= ST_ACCESS;
                    end else if (ack_cyc_s) begin
`ifdef Z80_TGT_INTACK_EN
                        cpu_din_r <= int_vec;
                        intack_r  <= 1'b1;
`else
                        cpu_din_r <= 8'hFF;
`endif
                        state_r   <= ST_DONE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    // An ack in the final counted cycle still wins over the abort.
                    if (bus_ack) begin
                        if (!bus_we_r) begin
                            cpu_din_r <= bus_rdata;
                        end else begin
                            cpu_din_r <= cpu_din_r;
                        end
                        bus_req_r <= 1'b0;
                        state_r   <= ST_DONE;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        cpu_din_r <= 8'hFF;
                        err_r     <= 1'b1;
                        bus_req_r <= 1'b0;
                        state_r   <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                ST_DONE: begin
                    if (strobes_idle_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    bus_req_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_z80_bus_target.sv
// Directed bench for z80_bus_target: a cycle-window model of each CPU cycle checks all outputs
// every cycle, and per-scenario literal expectations pin the model.
module tb_z80_bus_target;

    localparam int unsigned TO = 4;
`ifdef Z80_TGT_INTACK_EN
    localparam bit INTA_EN = 1'b1;
`else
    localparam bit INTA_EN = 1'b0;
`endif

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b0;
    logic        mreq_n    = 1'b1;
    logic        iorq_n    = 1'b1;
    logic        rd_n      = 1'b1;
    logic        wr_n      = 1'b1;
    logic        m1_n      = 1'b1;
    logic [15:0] A         = 16'h0000;
    logic [7:0]  cpu_dout  = 8'h00;
    logic        bus_ack   = 1'b0;
    logic [7:0]  bus_rdata = 8'h00;
    logic [7:0]  int_vec   = 8'h00;
    logic [7:0]  cpu_din;
    logic        wait_n;
    logic        bus_req;
    logic        bus_we;
    logic        bus_io;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        intack;
    logic        err;

    z80_bus_target #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
        .A(A), .cpu_dout(cpu_dout), .cpu_din(cpu_din), .wait_n(wait_n),
        .bus_req(bus_req), .bus_we(bus_we), .bus_io(bus_io),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .int_vec(int_vec), .intack(intack), .err(err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int n_wait = 0, n_req = 0, n_err = 0, n_intack = 0;
    int s_wait = 0, s_req = 0, s_err = 0, s_intack = 0;

    // Model of the current CPU cycle: kind 0 none, 1 backend, 2 interrupt acknowledge.
    int          m_kind = 0;
    int unsigned m_ts = 0, m_ack_at = 0;
    logic        m_has_ack = 1'b0;
    logic [7:0]  m_rdata = 8'h00, m_din_old = 8'h00, m_vec = 8'h00;
    logic [15:0] m_addr_old = 16'h0000, m_addr_new = 16'h0000;
    logic        m_we_old = 1'b0, m_we_new = 1'b0, m_io_old = 1'b0, m_io_new = 1'b0;
    logic [7:0]  m_wd_old = 8'h00, m_wd_new = 8'h00;

    function automatic int unsigned m_end();
        if (m_kind == 2) return m_ts;
        if (m_has_ack && (m_ack_at <= m_ts + TO)) return m_ack_at;
        return m_ts + TO;
    endfunction

    function automatic logic m_aborted();
        return (m_kind == 1) && !(m_has_ack && (m_ack_at <= m_ts + TO));
    endfunction

    function automatic logic [7:0] m_din_new();
        if (m_kind == 2) return m_vec;
        if (m_aborted()) return 8'hFF;
        if (m_we_new) return m_din_old;
        return m_rdata;
    endfunction

    task automatic m_roll();
        if (m_kind != 0) m_din_old = m_din_new();
        m_addr_old = m_addr_new;
        m_we_old   = m_we_new;
        m_io_old   = m_io_new;
        m_wd_old   = m_wd_new;
    endtask

    task automatic m_reset();
        m_kind = 0; m_has_ack = 1'b0; m_din_old = 8'h00;
        m_addr_old = 16'h0000; m_addr_new = 16'h0000;
        m_we_old = 1'b0; m_we_new = 1'b0; m_io_old = 1'b0; m_io_new = 1'b0;
        m_wd_old = 8'h00; m_wd_new = 8'h00;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic compare_loop();
        int unsigned t, te;
        logic        e_wait, e_req, e_err, e_intack, after;
        logic [7:0]  e_din;
        forever begin
            @(negedge clk);
            t = cyc;
            if (!reset_n) begin
                chk("wait_n_in_reset", 16'(wait_n), 16'd1);
            end else begin
                te       = m_end();
                e_wait   = !((m_kind != 0) && (t >= m_ts) && (t <= te));
                e_req    = (m_kind == 1) && (t > m_ts) && (t <= te);
                e_err    = m_aborted() && (t == te + 1);
                e_intack = INTA_EN && (m_kind == 2) && (t == m_ts + 1);
                e_din    = ((m_kind != 0) && (t > te)) ? m_din_new() : m_din_old;
                after    = (m_kind == 1) && (t > m_ts);
                chk("wait_n", 16'(wait_n), 16'(e_wait));
                chk("bus_req", 16'(bus_req), 16'(e_req));
                chk("err", 16'(err), 16'(e_err));
                chk("intack", 16'(intack), 16'(e_intack));
                chk("cpu_din", 16'(cpu_din), 16'(e_din));
                chk("bus_addr", bus_addr, after ? m_addr_new : m_addr_old);
                chk("bus_we", 16'(bus_we), 16'(after ? m_we_new : m_we_old));
                chk("bus_io", 16'(bus_io), 16'(after ? m_io_new : m_io_old));
                chk("bus_wdata", 16'(bus_wdata), 16'(after ? m_wd_new : m_wd_old));
                if (!wait_n) n_wait++;
                if (bus_req) n_req++;
                if (err) n_err++;
                if (intack) n_intack++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        s_wait = n_wait; s_req = n_req; s_err = n_err; s_intack = n_intack;
    endtask

    // k = cycle offset of the ack after the start cycle; k = 0 means no ack at all.
    task automatic backend_cycle(input logic [15:0] a, input logic is_wr, input logic is_io,
                                 input logic m1, input logic [7:0] dout, input int k,
                                 input logic [7:0] rdat);
        tick();
        m_roll();
        m_kind = 1; m_ts = cyc; m_has_ack = 1'b0; m_rdata = rdat;
        m_addr_new = a; m_we_new = is_wr; m_io_new = is_io; m_wd_new = dout;
        A = a; cpu_dout = dout; m1_n = m1;
        if (is_io) iorq_n = 1'b0; else mreq_n = 1'b0;
        if (is_wr) wr_n = 1'b0; else rd_n = 1'b0;
        if (k > 0) begin
            repeat (k) tick();
            bus_ack = 1'b1; bus_rdata = rdat; m_has_ack = 1'b1; m_ack_at = cyc;
            tick();
            bus_ack = 1'b0; bus_rdata = 8'h00;
        end
        while (cyc < m_end() + 2) tick();
        mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
        tick();
    endtask

    task automatic inta_cycle(input logic [7:0] v);
        tick();
        m_roll();
        m_kind = 2; m_ts = cyc; m_vec = INTA_EN ? v : 8'hFF;
        int_vec = v; iorq_n = 1'b0; m1_n = 1'b0;
        while (cyc < m_ts + 2) tick();
        iorq_n = 1'b1; m1_n = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        fork
            compare_loop();
        join_none
        m_reset();
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        chk("lit_reset_cpu_din", 16'(cpu_din), 16'h0000);
        chk("lit_reset_bus_req", 16'(bus_req), 16'h0000);
        chk("lit_reset_bus_addr", bus_addr, 16'h0000);

        snap();
        backend_cycle(16'h1234, 1'b0, 1'b0, 1'b1, 8'h00, 3, 8'h5A);
        chk("lit_memrd_wait_cycles", 16'(n_wait - s_wait), 16'd4);
        chk("lit_memrd_req_cycles", 16'(n_req - s_req), 16'd3);
        chk("lit_memrd_cpu_din", 16'(cpu_din), 16'h005A);
        chk("lit_memrd_addr", bus_addr, 16'h1234);
        chk("lit_memrd_we_io", {14'd0, bus_we, bus_io}, 16'd0);

        snap();
        backend_cycle(16'hA57F, 1'b1, 1'b1, 1'b1, 8'hC3, 1, 8'hEE);
        chk("lit_iowr_wait_cycles", 16'(n_wait - s_wait), 16'd2);
        chk("lit_iowr_addr_lo", 16'(bus_addr[7:0]), 16'h007F);
        chk("lit_iowr_wdata", 16'(bus_wdata), 16'h00C3);
        chk("lit_iowr_we_io", {14'd0, bus_we, bus_io}, 16'd3);
        chk("lit_iowr_din_kept", 16'(cpu_din), 16'h005A);

        backend_cycle(16'h8000, 1'b1, 1'b0, 1'b1, 8'h99, 2, 8'h00);
        backend_cycle(16'h0038, 1'b0, 1'b0, 1'b0, 8'h00, 1, 8'hC9);
        snap();
        backend_cycle(16'h0010, 1'b0, 1'b1, 1'b1, 8'h00, TO, 8'h3C);
        chk("lit_ack_at_limit_no_err", 16'(n_err - s_err), 16'd0);
        chk("lit_ack_at_limit_din", 16'(cpu_din), 16'h003C);

        snap();
        backend_cycle(16'h2000, 1'b0, 1'b0, 1'b1, 8'h00, 5, 8'h11);
        chk("lit_timeout_err_pulses", 16'(n_err - s_err), 16'd1);
        chk("lit_timeout_req_cycles", 16'(n_req - s_req), 16'd4);
        chk("lit_timeout_wait_cycles", 16'(n_wait - s_wait), 16'd5);
        chk("lit_timeout_cpu_din", 16'(cpu_din), 16'h00FF);
        backend_cycle(16'h2001, 1'b0, 1'b0, 1'b1, 8'h00, 1, 8'h77);
        chk("lit_after_timeout_din", 16'(cpu_din), 16'h0077);

        snap();
        inta_cycle(8'h40);
        chk("lit_inta_wait_cycles", 16'(n_wait - s_wait), 16'd1);
        chk("lit_inta_req_cycles", 16'(n_req - s_req), 16'd0);
        chk("lit_inta_intack", 16'(n_intack - s_intack), INTA_EN ? 16'd1 : 16'd0);
        chk("lit_inta_cpu_din", 16'(cpu_din), INTA_EN ? 16'h0040 : 16'h00FF);

        snap();
        tick();
        A = 16'h0055; mreq_n = 1'b0;
        tick(); tick();
        mreq_n = 1'b1;
        tick();
        chk("lit_refresh_wait_cycles", 16'(n_wait - s_wait), 16'd0);
        chk("lit_refresh_req_cycles", 16'(n_req - s_req), 16'd0);

        snap();
        tick();
        m_roll();
        m_kind = 1; m_ts = cyc; m_has_ack = 1'b0; m_rdata = 8'h00;
        m_addr_new = 16'h4000; m_we_new = 1'b0; m_io_new = 1'b0; m_wd_new = 8'h00;
        A = 16'h4000; cpu_dout = 8'h00; mreq_n = 1'b0; rd_n = 1'b0;
        tick(); tick();
        reset_n = 1'b0; mreq_n = 1'b1; rd_n = 1'b1;
        tick();
        reset_n = 1'b1;
        m_reset();
        chk("lit_rstmid_bus_req", 16'(bus_req), 16'd0);
        chk("lit_rstmid_wait_n", 16'(wait_n), 16'd1);
        tick(); tick();
        chk("lit_rstmid_no_err", 16'(n_err - s_err), 16'd0);

        backend_cycle(16'h0022, 1'b1, 1'b1, 1'b1, 8'h5E, 2, 8'h00);
        chk("lit_recover_wdata", 16'(bus_wdata), 16'h005E);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
